key_loader: RTL and testbench

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader.sv | 109 ++++++++++
 tb/tb_key_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// Double-buffered key assembler: words fill a shadow register, which is committed
// to the active key once the consumer has no key or releases the current one.
module key_loader #(
  parameter int WORD_W = 32,
  parameter int KEY_W  = 512
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iClear,
  input  logic [WORD_W-1:0]                   iWord,
  input  logic                                iWord_valid,
  output logic                                oWord_ready,
  input  logic                                iMsb_first,
  input  logic                                iKey_release,
  output logic [KEY_W-1:0]                    oKey,
  output logic                                oKey_valid,
  output logic                                oKey_loaded,
  output logic [$clog2(KEY_W/WORD_W+1)-1:0]   oFill_count,
  output logic [7:0]                          oKey_gen,
  output logic                                oOverflow
);

  localparam int N_WORDS = KEY_W / WORD_W;
  localparam int CNT_W   = $clog2(N_WORDS + 1);

  // state   | meaning
  // FILL    | shadow accepting words
  // PENDING | shadow full, waiting for the active slot to free up
  typedef enum logic {FILL, PENDING} state_t;

  state_t             state, stateNext;
  logic               accept, commit, dropWord, lastWord, msbSel, msbHeld;
  logic [CNT_W-1:0]   slot;
  logic [KEY_W-1:0]   shadow;

  assign lastWord = (oFill_count == CNT_W'(N_WORDS - 1));
  // Word order is latched on the first word so mid-key toggles are ignored.
  assign msbSel   = (oFill_count == '0) ? iMsb_first : msbHeld;
  assign slot     = msbSel ? (CNT_W'(N_WORDS - 1) - oFill_count) : oFill_count;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)       state <= FILL;
    else if (iClear) state <= FILL;
    else             state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    oWord_ready = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    dropWord    = 1'b0;
    case (state)
      FILL: begin
        oWord_ready = 1'b1;
        accept      = iWord_valid;
        if (accept && lastWord) stateNext = PENDING;
      end
      PENDING: begin
        dropWord = iWord_valid;
        commit   = !oKey_valid || iKey_release;
        if (commit) stateNext = FILL;
      end
      default: stateNext = FILL;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      shadow      <= '0;
      oKey        <= '0;
      oKey_valid  <= 1'b0;
      oKey_loaded <= 1'b0;
      oFill_count <= '0;
      oKey_gen    <= '0;
      oOverflow   <= 1'b0;
      msbHeld     <= 1'b0;
    end else if (iClear) begin
      shadow      <= '0;
      oKey        <= '0;
      oKey_valid  <= 1'b0;
      oKey_loaded <= 1'b0;
      oFill_count <= '0;
      oKey_gen    <= '0;
      oOverflow   <= 1'b0;
      msbHeld     <= 1'b0;
    end else begin
      oKey_loaded <= commit;
      if (dropWord) oOverflow <= 1'b1;
      if (accept) begin
        shadow[slot*WORD_W +: WORD_W] <= iWord;
        oFill_count <= oFill_count + 1'b1;
        if (oFill_count == '0) msbHeld <= iMsb_first;
      end
      // A release arriving with a commit is absorbed by the commit; key stays valid.
      if (commit) begin
        oKey        <= shadow;
        oKey_valid  <= 1'b1;
        oKey_gen    <= oKey_gen + 8'd1;
        shadow      <= '0;
        oFill_count <= '0;
      end else if (iKey_release && oKey_valid) begin
        oKey       <= '0;
        oKey_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader (32-bit words, 512-bit key) with a small
// slot model building the expected key from the words the bench offers.
module tb_key_loader;

  logic         iClk = 1'b0;
  logic         iRst = 1'b0;
  logic         iClear = 1'b0;
  logic [31:0]  iWord = '0;
  logic         iWord_valid = 1'b0;
  logic         oWord_ready;
  logic         iMsb_first = 1'b0;
  logic         iKey_release = 1'b0;
  logic [511:0] oKey;
  logic         oKey_valid;
  logic         oKey_loaded;
  logic [4:0]   oFill_count;
  logic [7:0]   oKey_gen;
  logic         oOverflow;

  int testsRun = 0;
  int testsFailed = 0;
  logic [511:0] keyA, keyB, expKey;
  int acc;

  key_loader #(.WORD_W(32), .KEY_W(512)) dut (
    .iClk(iClk), .iRst(iRst), .iClear(iClear), .iWord(iWord),
    .iWord_valid(iWord_valid), .oWord_ready(oWord_ready), .iMsb_first(iMsb_first),
    .iKey_release(iKey_release), .oKey(oKey), .oKey_valid(oKey_valid),
    .oKey_loaded(oKey_loaded), .oFill_count(oFill_count), .oKey_gen(oKey_gen),
    .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Offer 16 back-to-back words base+1..base+16; msbFirst applies to word 0,
  // later words toggle iMsb_first to show it is ignored mid-key.
  task automatic loadKey(input logic [31:0] base, input logic msbFirst, output logic [511:0] model);
    model = '0;
    for (int i = 0; i < 16; i++) begin
      iWord       = base + 32'(i + 1);
      iWord_valid = 1'b1;
      iMsb_first  = (i == 0) ? msbFirst : logic'(i % 2);
      if (msbFirst) model[(15 - i)*32 +: 32] = iWord;
      else          model[i*32 +: 32] = iWord;
      step();
    end
    iWord_valid = 1'b0;
    iMsb_first  = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_key", oKey, '0);
    check("rst_valid", {511'b0, oKey_valid}, 512'd0);
    check("rst_ready", {511'b0, oWord_ready}, 512'd1);
    check("rst_fill", {507'b0, oFill_count}, 512'd0);
    check("rst_gen", {504'b0, oKey_gen}, 512'd0);
    check("rst_ovf", {511'b0, oOverflow}, 512'd0);
    iRst = 1'b1;
    step();

    // LSB-first, no key active: commit one cycle after the last word
    loadKey(32'h0, 1'b0, keyA);
    check("lsb_fill16", {507'b0, oFill_count}, 512'd16);
    check("lsb_ready0", {511'b0, oWord_ready}, 512'd0);
    step();
    check("lsb_low", {480'b0, oKey[31:0]}, 512'h1);
    check("lsb_high", {480'b0, oKey[511:480]}, 512'h10);
    check("lsb_key", oKey, keyA);
    check("lsb_valid", {511'b0, oKey_valid}, 512'd1);
    check("lsb_loaded", {511'b0, oKey_loaded}, 512'd1);
    check("lsb_gen", {504'b0, oKey_gen}, 512'd1);
    check("lsb_fill0", {507'b0, oFill_count}, 512'd0);
    step();
    check("lsb_loaded_once", {511'b0, oKey_loaded}, 512'd0);
    check("lsb_ovf", {511'b0, oOverflow}, 512'd0);

    // release with nothing pending clears the active key
    iKey_release = 1'b1;
    step();
    iKey_release = 1'b0;
    check("rel_key", oKey, '0);
    check("rel_valid", {511'b0, oKey_valid}, 512'd0);

    // MSB-first with mid-key toggling of iMsb_first
    loadKey(32'h0, 1'b1, keyA);
    step();
    check("msb_high", {480'b0, oKey[511:480]}, 512'h1);
    check("msb_low", {480'b0, oKey[31:0]}, 512'h10);
    check("msb_key", oKey, keyA);
    check("msb_gen", {504'b0, oKey_gen}, 512'd2);

    // key B waits behind active key A; extra word overflows
    loadKey(32'h100, 1'b0, keyB);
    step();
    step();
    check("pend_ready", {511'b0, oWord_ready}, 512'd0);
    check("pend_keyA", oKey, keyA);
    check("pend_loaded", {511'b0, oKey_loaded}, 512'd0);
    iWord = 32'hDEAD_BEEF;
    iWord_valid = 1'b1;
    step();
    iWord_valid = 1'b0;
    check("ovf_set", {511'b0, oOverflow}, 512'd1);
    check("ovf_keyA", oKey, keyA);
    iKey_release = 1'b1;
    step();
    iKey_release = 1'b0;
    check("swap_keyB", oKey, keyB);
    check("swap_valid", {511'b0, oKey_valid}, 512'd1);
    check("swap_gen", {504'b0, oKey_gen}, 512'd3);
    check("swap_loaded", {511'b0, oKey_loaded}, 512'd1);
    step();
    check("ovf_sticky", {511'b0, oOverflow}, 512'd1);

    // iClear wins over a simultaneous word and release
    iClear = 1'b1;
    iWord_valid = 1'b1;
    iWord = 32'h55;
    iKey_release = 1'b1;
    step();
    iClear = 1'b0;
    iWord_valid = 1'b0;
    iKey_release = 1'b0;
    check("clr_key", oKey, '0);
    check("clr_valid", {511'b0, oKey_valid}, 512'd0);
    check("clr_gen", {504'b0, oKey_gen}, 512'd0);
    check("clr_ovf", {511'b0, oOverflow}, 512'd0);
    check("clr_fill", {507'b0, oFill_count}, 512'd0);

    // async reset mid-fill discards partial words
    for (int i = 0; i < 7; i++) begin
      iWord = 32'hA0 + 32'(i);
      iWord_valid = 1'b1;
      step();
    end
    iWord_valid = 1'b0;
    check("part_fill7", {507'b0, oFill_count}, 512'd7);
    #2 iRst = 1'b0;
    #1;
    check("arst_fill", {507'b0, oFill_count}, 512'd0);
    check("arst_ready", {511'b0, oWord_ready}, 512'd1);
    check("arst_key", oKey, '0);
    check("arst_gen", {504'b0, oKey_gen}, 512'd0);
    @(negedge iClk);
    iRst = 1'b1;
    step();
    loadKey(32'h200, 1'b0, keyA);
    step();
    check("arst_reload", oKey, keyA);
    check("arst_regen", {504'b0, oKey_gen}, 512'd1);

    // free the active slot, then random gaps on iWord_valid
    iKey_release = 1'b1;
    step();
    iKey_release = 1'b0;
    expKey = '0;
    acc = 0;
    for (int cyc = 0; cyc < 400 && acc < 16; cyc++) begin
      iWord = $urandom;
      iWord_valid = logic'($urandom_range(0, 1));
      if (iWord_valid) begin
        expKey[acc*32 +: 32] = iWord;
        acc++;
      end
      step();
      if (acc < 16) check("gap_fill", {507'b0, oFill_count}, 512'(acc));
    end
    iWord_valid = 1'b0;
    check("gap_done", 512'(acc), 512'd16);
    step();
    check("gap_key", oKey, expKey);
    check("gap_gen", {504'b0, oKey_gen}, 512'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
